mult_acc_q: RTL
===============

# mult_acc_q

Sequential unsigned shift-add multiply-accumulate unit computing P = Q*B + R on 9-bit operands. It is the inverse of the 9-bit restoring divider: it rebuilds the dividend from a divider's quotient, divisor and remainder. It is used as a self-check stage behind `dividerQ`/`divider`/`dividerQ2`, and as a standalone multiplier. It uses the same start/ready handshake and bus style as the dividers.

## Interface
- No parameters; operand width is fixed at 9 bits and result width at 18 bits.
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level-sampled request; accepted only while `ready`=1.
- `Qbus`  in  9  multiplier (quotient), unsigned.
- `Bbus`  in  9  multiplicand (divisor), unsigned.
- `Rbus`  in  9  addend (remainder), unsigned.
- `Pbus`  out  18  result Q*B+R, registered.
- `ovf`  out  1  result does not fit in 9 bits (`Pbus[17:9]`≠0), registered.
- `ready`  out  1  idle/done; high when a new start can be accepted.

## Operation
- States:
  - `IDLE`: ready=1.
  - `MUL`: ready=0, 9 iterations.
  - `DONE`: ready=1, result valid.
- `IDLE`/`DONE` with start=1 → load and go to `MUL`. On load:
  - acc ← {9'b0, Rbus}
  - mreg ← {9'b0, Bbus} (18 bits)
  - qreg ← Qbus
  - cnt ← 0
  - ready ← 0
- `MUL` step, per cycle:
  - if qreg[0], acc ← acc + mreg
  - mreg ← mreg<<1
  - qreg ← qreg>>1
  - cnt ← cnt+1
- After the step with cnt=8, go to `DONE` and register the results:
  - Pbus ← final acc
  - ovf ← |final acc[17:9]
- `DONE` with start=0 stays in `DONE` and holds Pbus/ovf. `IDLE` exists only after reset.
- Arithmetic: everything is unsigned, with no truncation. The maximum is 511*511+511 = 261632 < 2^18, so the 18-bit acc never carries out.
- Operand buses are sampled only on the load edge. Changes on the buses during `MUL` have no effect.
- start=1 during `MUL` is ignored, with no queuing.
- start still high on the edge after `DONE` is entered launches a new operation using the current bus values. Drivers must drop start before completion if a single operation is wanted.
- Pbus/ovf change only on entry to `DONE` and hold the previous result throughout `MUL`.
- Reset (rst=0, any time, including mid-operation), asynchronously:
  - state → `IDLE`
  - Pbus → 0
  - ovf → 0
  - ready → 1
  - acc, mreg, qreg, cnt → 0
- Operation resumes only on a start sampled after rst returns high.

## Timing
- Load edge = edge E (start=1, ready=1). ready is low from E.
- The 9 `MUL` steps occur on edges E+1 … E+9.
- Pbus/ovf update and ready rises on edge E+9. Latency is 9 cycles start-to-ready, 10 edges including the load.
- Back-to-back throughput: one result per 10 cycles when start is held high.
- Reset values: Pbus=0, ovf=0, ready=1, regardless of clock.
- The start-to-load path is synchronous. start needs no edge detection.

## Test plan
- Reset, then Q=32, B=2, R=1, start pulsed for 1 cycle → ready low for 9 cycles, then Pbus=65 (9'b001000001), ovf=0, ready=1.
- Q=85, B=3, R=2 → Pbus=257, ovf=0. Feed the outputs of `dividerQ` for A=257, B=3 into mult_acc_q → Pbus equals the original dividend.
- Q=511, B=511, R=511 → Pbus=261632, ovf=1. Q=0, B=400, R=7 → Pbus=7, ovf=0.
- Change Qbus/Bbus/Rbus and pulse start during `MUL` → the result matches the originally loaded operands, and ready stays low for the full 9 cycles.
- Assert rst=0 at cycle 4 of `MUL` (off the clock edge) → Pbus=0, ovf=0, ready=1 immediately. A new start after release yields a correct full result.
- Hold start high across completion → ready high for exactly one cycle at `DONE`, then a second operation launches and a second valid result appears 10 edges later.

Source files
------------

// File: rtl/mult_acc_q.sv
// Shift-add unsigned multiply-accumulate P = Q*B + R on 9-bit operands; 9 cycles start-to-ready.
// No queuing: start is honoured only while ready is high, and a held start relaunches on DONE.
module mult_acc_q (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  Qbus,
    input  logic [8:0]  Bbus,
    input  logic [8:0]  Rbus,
    output logic [17:0] Pbus,
    output logic        ovf,
    output logic        ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] acc_q,   acc_d;
    logic [17:0] mreg_q,  mreg_d;
    logic [8:0]  qreg_q,  qreg_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [17:0] pbus_q,  pbus_d;
    logic        ovf_q,   ovf_d;
    logic [17:0] acc_sum;

    // Worst case 511*511+511 fits in 18 bits, so the add never carries out.
    assign acc_sum = qreg_q[0] ? (acc_q + mreg_q) : acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mreg_q  <= '0;
            qreg_q  <= '0;
            cnt_q   <= '0;
            pbus_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mreg_q  <= mreg_d;
            qreg_q  <= qreg_d;
            cnt_q   <= cnt_d;
            pbus_q  <= pbus_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mreg_d  = mreg_q;
        qreg_d  = qreg_q;
        cnt_d   = cnt_q;
        pbus_d  = pbus_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = MUL;
                    acc_d   = {9'b0, Rbus};
                    mreg_d  = {9'b0, Bbus};
                    qreg_d  = Qbus;
                    cnt_d   = 4'd0;
                end
            end
            MUL: begin
                acc_d  = acc_sum;
                mreg_d = mreg_q << 1;
                qreg_d = qreg_q >> 1;
                cnt_d  = cnt_q + 4'd1;
                // Results are published only on the last step so Pbus holds during MUL.
                if (cnt_q == 4'd8) begin
                    state_d = DONE;
                    pbus_d  = acc_sum;
                    ovf_d   = |acc_sum[17:9];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Pbus  = pbus_q;
    assign ovf   = ovf_q;
    assign ready = (state_q != MUL);

endmodule
